// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port synchronous memory between the CPU (port 0)
// and a debug/DMA master (port 1); each transaction runs IDLE->ACC->RESP->DONE.
module mem_arbiter #(
    parameter int WIDTH         = 32,
    parameter int MEM_ADDR_SIZE = 12,
    parameter int ARB_MODE      = 0,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m0_req,
    input  logic                     m0_wen,
    input  logic [MEM_ADDR_SIZE-1:0] m0_addr,
    input  logic [WIDTH-1:0]         m0_wdata,
    output logic [WIDTH-1:0]         m0_rdata,
    output logic                     m0_ack,
    input  logic                     m1_req,
    input  logic                     m1_wen,
    input  logic [MEM_ADDR_SIZE-1:0] m1_addr,
    input  logic [WIDTH-1:0]         m1_wdata,
    output logic [WIDTH-1:0]         m1_rdata,
    output logic                     m1_ack,
    output logic                     mem_cs,
    output logic                     mem_wen,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    output logic                     grant,
    output logic                     busy
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]               state;
    logic                     grant_q;
    logic                     wen_q;
    logic [MEM_ADDR_SIZE-1:0] addr_q;
    logic [WIDTH-1:0]         wdata_q;
    logic [CW-1:0]            starve_cnt;
    logic                     pick;

    // Winner for this IDLE cycle; only meaningful when at least one port requests.
    always_comb begin
        pick = 1'b0;
        case ({m1_req, m0_req})
            2'b10: pick = 1'b1;
            2'b11: begin
                if (ARB_MODE == 0) pick = ~grant_q;
                else               pick = (starve_cnt == LIMIT);
            end
            default: pick = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant_q    <= 1'b1;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_cnt <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state   <= ACC;
                        grant_q <= pick;
                        wen_q   <= pick ? m1_wen   : m0_wen;
                        addr_q  <= pick ? m1_addr  : m0_addr;
                        wdata_q <= pick ? m1_wdata : m0_wdata;
                    end
                    // Counts contested port-0 wins; saturates at the limit instead of wrapping.
                    if (!m1_req || pick)
                        starve_cnt <= '0;
                    else if (m0_req && starve_cnt != LIMIT)
                        starve_cnt <= starve_cnt + CW'(1);
                end
                ACC:  state <= RESP;
                RESP: begin
                    state <= DONE;
                    if (grant_q) m1_ack <= 1'b1;
                    else         m0_ack <= 1'b1;
                    if (!wen_q) begin
                        if (grant_q) m1_rdata <= mem_rdata;
                        else         m0_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_cs    = (state == ACC);
    assign mem_wen   = (state == ACC) && wen_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant     = grant_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin instance (a) and one fixed-priority
// instance (b, STARVE_LIMIT=4), each backed by its own 1-cycle synchronous memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wen, m1_req, m1_wen;
    logic [11:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;

    logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
    logic        a_m0_ack, a_m1_ack, a_mem_cs, a_mem_wen, a_grant, a_busy;
    logic [11:0] a_mem_addr;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_m0_ack, b_m1_ack, b_mem_cs, b_mem_wen, b_grant, b_busy;
    logic [11:0] b_mem_addr;

    logic [31:0] mem_a [0:4095];
    logic [31:0] mem_b [0:4095];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(32), .MEM_ADDR_SIZE(12), .ARB_MODE(0), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack),
        .mem_cs(a_mem_cs), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .grant(a_grant), .busy(a_busy)
    );

    mem_arbiter #(.WIDTH(32), .MEM_ADDR_SIZE(12), .ARB_MODE(1), .STARVE_LIMIT(4)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
        .mem_cs(b_mem_cs), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .grant(b_grant), .busy(b_busy)
    );

    always @(posedge clk) begin
        if (a_mem_cs) begin
            if (a_mem_wen) mem_a[a_mem_addr] <= a_mem_wdata;
            a_mem_rdata <= mem_a[a_mem_addr];
        end
        if (b_mem_cs) begin
            if (b_mem_wen) mem_b[b_mem_addr] <= b_mem_wdata;
            b_mem_rdata <= mem_b[b_mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-requester transaction on instance a with full cycle-by-cycle checks.
    task automatic txn(input logic port, input logic wen, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
        if (port) begin
            m1_req = 1'b1; m1_wen = wen; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_wen = wen; m0_addr = addr; m0_wdata = wdata;
        end
        check({tag, " idle_cs"}, {31'd0, a_mem_cs}, 32'd0);
        step();
        check({tag, " grant"}, {31'd0, a_grant}, {31'd0, port});
        check({tag, " acc_cs"}, {31'd0, a_mem_cs}, 32'd1);
        check({tag, " acc_wen"}, {31'd0, a_mem_wen}, {31'd0, wen});
        check({tag, " acc_addr"}, {20'd0, a_mem_addr}, {20'd0, addr});
        if (wen) check({tag, " acc_wdata"}, a_mem_wdata, wdata);
        step();
        check({tag, " resp_cs"}, {31'd0, a_mem_cs}, 32'd0);
        check({tag, " resp_wen"}, {31'd0, a_mem_wen}, 32'd0);
        check({tag, " resp_ack0"}, {31'd0, a_m0_ack}, 32'd0);
        step();
        check({tag, " ack_m0"}, {31'd0, a_m0_ack}, {31'd0, ~port});
        check({tag, " ack_m1"}, {31'd0, a_m1_ack}, {31'd0, port});
        check({tag, " rdata"}, port ? a_m1_rdata : a_m0_rdata, exp_rd);
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
        check({tag, " ack_drop"}, {30'd0, a_m1_ack, a_m0_ack}, 32'd0);
        check({tag, " idle_busy"}, {31'd0, a_busy}, 32'd0);
    endtask

    // One 4-cycle transaction with both ports requesting; checks grant and ack position.
    task automatic both_txn(input logic use_b, input logic exp_g, input string tag);
        step();
        check({tag, " grant"}, {31'd0, use_b ? b_grant : a_grant}, {31'd0, exp_g});
        step();
        step();
        check({tag, " ack"}, {30'd0, use_b ? {b_m1_ack, b_m0_ack} : {a_m1_ack, a_m0_ack}},
              exp_g ? 32'd2 : 32'd1);
        if (!use_b) begin
            if (exp_g) check({tag, " m1_rdata_kept"}, a_m1_rdata, 32'h12345678);
            else       check({tag, " m0_rdata"}, a_m0_rdata, 32'hDEADBEEF);
        end
        step();
        check({tag, " ack_gap"}, {30'd0, use_b ? {b_m1_ack, b_m0_ack} : {a_m1_ack, a_m0_ack}},
              32'd0);
    endtask

    logic seq5a [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic seq5b [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b0;
        m0_req = 1'b0; m0_wen = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wen = 1'b0; m1_addr = '0; m1_wdata = '0;
        a_mem_rdata = 'x;
        b_mem_rdata = 'x;
        mem_a[12'h010] = 32'hDEADBEEF;
        mem_b[12'h010] = 32'hDEADBEEF;

        // Test 1: reset state with memory data undriven
        step();
        step();
        check("rst m0_ack", {31'd0, a_m0_ack}, 32'd0);
        check("rst m1_ack", {31'd0, a_m1_ack}, 32'd0);
        check("rst m0_rdata", a_m0_rdata, 32'd0);
        check("rst m1_rdata", a_m1_rdata, 32'd0);
        check("rst mem_cs", {31'd0, a_mem_cs}, 32'd0);
        check("rst mem_wen", {31'd0, a_mem_wen}, 32'd0);
        check("rst mem_addr", {20'd0, a_mem_addr}, 32'd0);
        check("rst mem_wdata", a_mem_wdata, 32'd0);
        check("rst grant", {31'd0, a_grant}, 32'd1);
        check("rst busy", {31'd0, a_busy}, 32'd0);
        check("rst grant_b", {31'd0, b_grant}, 32'd1);
        reset = 1'b1;
        step();
        step();
        check("rel busy", {31'd0, a_busy}, 32'd0);
        check("rel mem_cs", {31'd0, a_mem_cs}, 32'd0);

        // Test 2 and address boundaries on port 0
        txn(1'b0, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, "t2 rd");
        txn(1'b0, 1'b1, 12'h000, 32'hCAFEF00D, 32'hDEADBEEF, "t2 wr0");
        txn(1'b0, 1'b0, 12'h000, 32'h0, 32'hCAFEF00D, "t2 rd0");

        // Test 3: port 1 write then read at the top address
        txn(1'b1, 1'b1, 12'hFFF, 32'h12345678, 32'h0, "t3 wr");
        txn(1'b1, 1'b0, 12'hFFF, 32'h0, 32'h12345678, "t3 rd");

        // Test 4: round-robin with both ports held high
        m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 12'h010;
        m1_req = 1'b1; m1_wen = 1'b1; m1_addr = 12'h020; m1_wdata = 32'hA5A5A5A5;
        for (int unsigned k = 0; k < 4; k++)
            both_txn(1'b0, k[0], "t4 rr");
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();

        // Test 5: fixed priority with starvation guard on instance b
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int unsigned k = 0; k < 7; k++)
            both_txn(1'b1, seq5a[k], "t5 prio");
        m1_req = 1'b0;
        both_txn(1'b1, 1'b0, "t5 solo");
        m1_req = 1'b1;
        for (int unsigned k = 0; k < 5; k++)
            both_txn(1'b1, seq5b[k], "t5 clr");
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();

        // Test 6: reset during ACC aborts; a later port-1 read completes
        m0_req = 1'b1; m0_wen = 1'b0; m0_addr = 12'h010;
        step();
        check("t6 acc_cs", {31'd0, a_mem_cs}, 32'd1);
        reset = 1'b0;
        #1;
        check("t6 abort_cs", {31'd0, a_mem_cs}, 32'd0);
        check("t6 abort_busy", {31'd0, a_busy}, 32'd0);
        m0_req = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            check("t6 no_ack", {30'd0, a_m1_ack, a_m0_ack}, 32'd0);
        end
        reset = 1'b1;
        step();
        txn(1'b1, 1'b0, 12'hFFF, 32'h0, 32'h12345678, "t6 rd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
